elevator_scheduler: RTL and testbench
=====================================

# elevator_scheduler

Collective (SCAN) scheduler for the 4-floor elevator. It latches hall calls (floor + up/down) and cabin calls, and picks travel direction and stops. It drives the motor up/down and door-open outputs, and tracks the current floor from arrival pulses. It sits between the button/switch decode in `Interface` and the level, door and direction indicators (`Level`, `AbreCierra`, `SubeBaja`).

## Interface
- `DOOR_CYCLES`, 8: cycles `door_open` stays high per stop; must be ≥ 2.
- `clk`  in  1  system clock. One clock only.
- `reset`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  advance enable; 0 freezes FSM, floor counter and door timer. Call latching continues.
- `hall_req`  in  1  one-cycle hall-call strobe.
- `hall_floor`  in  2  hall-call floor, 0..3.
- `hall_up`  in  1  hall-call direction: 1 = up, 0 = down.
- `cab_req`  in  1  one-cycle cabin-call strobe.
- `cab_floor`  in  2  cabin-call floor.
- `floor_arrive`  in  1  one-cycle pulse: cabin reached the next floor in `dir_up`.
- `cur_floor`  out  2  current floor.
- `motor_up`, `motor_down`  out  1 each  motor drive; never both high.
- `door_open`  out  1  door open (AbreCierra).
- `dir_up`  out  1  travel/preference direction (SubeBaja).
- `pending`  out  4  per-floor OR of all latched calls.

## Operation
- Call registers: `up_calls[3:0]`, `dn_calls[3:0]`, `cab_calls[3:0]`.
  - An up call at floor 3 or a down call at floor 0 is dropped.
  - A strobe sets its bit at the next edge. It is visible to the FSM one cycle later.
- "Above" means any call at a floor > `cur_floor`. "Below" means any call at a floor < `cur_floor`.
- States: IDLE, MOVING, DOOR.
- IDLE:
  - Any call at `cur_floor` → DOOR, and clear that floor's bits.
  - Else if calls both above and below, keep the current `dir_up`.
  - Else if calls only above: `dir_up`=1 → MOVING. If only below: `dir_up`=0 → MOVING.
  - Else stay in IDLE.
- MOVING, on `floor_arrive`:
  - `cur_floor` ±1, saturating at 0 and 3.
  - Stop if the new floor has one of: a cabin call; a hall call in `dir_up`; a hall call opposite to `dir_up` with nothing further ahead.
  - Stop → DOOR, clearing the cabin call and the served hall call(s). Otherwise stay in MOVING.
  - `floor_arrive` outside MOVING, or with `enable`=0, is ignored.
- DOOR:
  - Timer loads `DOOR_CYCLES`-1 on entry and counts down.
  - Calls at `cur_floor` in the served direction, or cabin calls there, are not latched; they reload the timer.
  - Timer at 0 → requests ahead in `dir_up` → MOVING, same direction. Else requests behind → flip `dir_up`, MOVING. Else → IDLE.
- Outputs decode from the state register:
  - `motor_up` = MOVING & `dir_up`; `motor_down` = MOVING & !`dir_up`.
  - `door_open` = DOOR.
- Reset values: state IDLE, all calls 0, `cur_floor`=0, `dir_up`=1, `door_open`=0, motors 0, `pending`=0.
- Reset mid-travel or mid-door discards all calls immediately.

## Timing
- Call latency (IDLE, other floor): strobe at edge N, bit set at N, state MOVING at N+1, motor output high from N+1.
- Arrival stop: `floor_arrive` sampled at edge E. `cur_floor` updates, `door_open` rises and the motor drops at E.
- Door dwell: `door_open` high exactly `DOOR_CYCLES` cycles with no reload or `enable` low. The next state is entered at the following edge.
- Simultaneous `hall_req` and `cab_req` are both latched.
- A strobe for a bit being cleared on the same edge is lost only if it matches the served floor/direction. That counts as served.

## Structure
- `elevator_pkg` holds:
  - the state enum (IDLE/MOVING/DOOR);
  - `NFLOORS=4`;
  - `floor_t` (logic [1:0]);
  - helper functions `any_above` and `any_below`.
- Sub-module `elevator_call_regs`: the three call vectors, set/clear logic, and the `pending` output.
- The FSM, floor counter and door timer live in the top module.

## Test plan
- Reset, then cab_req floor 3 at floor 0:
  - `motor_up` high 2 cycles later;
  - three `floor_arrive` pulses → `cur_floor`=3;
  - `door_open` for 8 cycles, then IDLE with `pending`=0.
- Moving up from 0 with hall up at floor 1 and cab floor 3 → stops at 1 (door 8 cycles), continues, stops at 3.
- Moving up to 3 with hall down at 2 → passes floor 2 without stopping; stops at 3, reverses, stops at 2.
- During DOOR at floor 2, cab_req floor 2 at dwell cycle 5 → `door_open` total 5+8 cycles.
- Hall up at floor 3 and hall down at floor 0 → `pending` stays 0, state stays IDLE.
- Assert `reset` mid-MOVING at floor 1 → all outputs 0 and `cur_floor`=0 immediately; `enable`=0 freezes the door timer count.

Source files
------------

// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elevator_pkg
// Description : Shared types, constants and call-scan helpers for the
//               4-floor SCAN elevator scheduler.
// Revision    : 1.0
// ============================================================================
package elevator_pkg;

    localparam int NFLOORS = 4;

    typedef logic [1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        DOOR   = 2'd2
    } state_t;

    function automatic logic any_above(input logic [NFLOORS-1:0] calls, input floor_t f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NFLOORS; i++) begin
            if (i > int'(f)) r = r | calls[i];
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [NFLOORS-1:0] calls, input floor_t f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NFLOORS; i++) begin
            if (i < int'(f)) r = r | calls[i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_call_regs.sv
`default_nettype none
// ============================================================================
// Module      : elevator_call_regs
// Description : Latches hall (up/down) and cabin calls; clear masks from the
//               scheduler both retire served calls and block same-edge strobes.
// Revision    : 1.0
// ============================================================================
module elevator_call_regs
    import elevator_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_hall_req,
    input  floor_t             i_hall_floor,
    input  logic               i_hall_up,
    input  logic               i_cab_req,
    input  floor_t             i_cab_floor,
    input  logic [NFLOORS-1:0] i_clr_up,
    input  logic [NFLOORS-1:0] i_clr_dn,
    input  logic [NFLOORS-1:0] i_clr_cab,
    output logic [NFLOORS-1:0] o_up_calls,
    output logic [NFLOORS-1:0] o_dn_calls,
    output logic [NFLOORS-1:0] o_cab_calls,
    output logic [NFLOORS-1:0] o_pending
);

    localparam floor_t             c_top_floor = floor_t'(NFLOORS - 1);
    localparam logic [NFLOORS-1:0] c_one       = {{(NFLOORS-1){1'b0}}, 1'b1};

    logic [NFLOORS-1:0] r_up_calls;
    logic [NFLOORS-1:0] r_dn_calls;
    logic [NFLOORS-1:0] r_cab_calls;
    logic [NFLOORS-1:0] w_set_up;
    logic [NFLOORS-1:0] w_set_dn;
    logic [NFLOORS-1:0] w_set_cab;

    // Up at the top floor and down at the ground floor are meaningless and dropped.
    assign w_set_up  = (i_hall_req && i_hall_up && (i_hall_floor != c_top_floor))
                       ? (c_one << i_hall_floor) : '0;
    assign w_set_dn  = (i_hall_req && !i_hall_up && (i_hall_floor != floor_t'(0)))
                       ? (c_one << i_hall_floor) : '0;
    assign w_set_cab = i_cab_req ? (c_one << i_cab_floor) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_up_calls  <= '0;
            r_dn_calls  <= '0;
            r_cab_calls <= '0;
        end else begin
            r_up_calls  <= (r_up_calls  | w_set_up)  & ~i_clr_up;
            r_dn_calls  <= (r_dn_calls  | w_set_dn)  & ~i_clr_dn;
            r_cab_calls <= (r_cab_calls | w_set_cab) & ~i_clr_cab;
        end
    end

    assign o_up_calls  = r_up_calls;
    assign o_dn_calls  = r_dn_calls;
    assign o_cab_calls = r_cab_calls;
    assign o_pending   = r_up_calls | r_dn_calls | r_cab_calls;

endmodule
`default_nettype wire

// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : elevator_scheduler
// Description : Collective (SCAN) scheduler: direction choice, stop decision,
//               floor tracking and door dwell timing for a 4-floor car.
// Revision    : 1.0
// ============================================================================
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       hall_req,
    input  logic [1:0] hall_floor,
    input  logic       hall_up,
    input  logic       cab_req,
    input  logic [1:0] cab_floor,
    input  logic       floor_arrive,
    output logic [1:0] cur_floor,
    output logic       motor_up,
    output logic       motor_down,
    output logic       door_open,
    output logic       dir_up,
    output logic [3:0] pending
);

    localparam int                 c_tmr_w     = $clog2(DOOR_CYCLES);
    localparam logic [c_tmr_w-1:0] c_tmr_load  = c_tmr_w'(DOOR_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_one   = c_tmr_w'(1);
    localparam floor_t             c_top_floor = floor_t'(NFLOORS - 1);
    localparam logic [NFLOORS-1:0] c_one       = {{(NFLOORS-1){1'b0}}, 1'b1};

    state_t             r_state,     w_state_nxt;
    floor_t             r_cur_floor, w_floor_nxt;
    logic               r_dir_up,    w_dir_nxt;
    logic [c_tmr_w-1:0] r_timer,     w_timer_nxt;

    logic [NFLOORS-1:0] w_up_calls, w_dn_calls, w_cab_calls, w_all_calls;
    logic [NFLOORS-1:0] w_clr_up, w_clr_dn, w_clr_cab;
    logic [NFLOORS-1:0] w_cur_oh, w_arr_oh;
    floor_t             w_arr_floor;
    logic               w_above, w_below, w_cur_ahead, w_cur_behind;
    logic               w_arr_ahead, w_arr_stop, w_hall_ok, w_door_hit;

    elevator_call_regs u_call_regs (
        .clk          (clk),
        .rst          (reset),
        .i_hall_req   (hall_req),
        .i_hall_floor (hall_floor),
        .i_hall_up    (hall_up),
        .i_cab_req    (cab_req),
        .i_cab_floor  (cab_floor),
        .i_clr_up     (w_clr_up),
        .i_clr_dn     (w_clr_dn),
        .i_clr_cab    (w_clr_cab),
        .o_up_calls   (w_up_calls),
        .o_dn_calls   (w_dn_calls),
        .o_cab_calls  (w_cab_calls),
        .o_pending    (w_all_calls)
    );

    assign w_above      = any_above(w_all_calls, r_cur_floor);
    assign w_below      = any_below(w_all_calls, r_cur_floor);
    assign w_cur_ahead  = r_dir_up ? w_above : w_below;
    assign w_cur_behind = r_dir_up ? w_below : w_above;
    assign w_cur_oh     = c_one << r_cur_floor;

    assign w_arr_floor  = r_dir_up
                          ? ((r_cur_floor == c_top_floor) ? r_cur_floor : r_cur_floor + floor_t'(1))
                          : ((r_cur_floor == floor_t'(0)) ? r_cur_floor : r_cur_floor - floor_t'(1));
    assign w_arr_oh     = c_one << w_arr_floor;
    assign w_arr_ahead  = r_dir_up ? any_above(w_all_calls, w_arr_floor)
                                   : any_below(w_all_calls, w_arr_floor);
    // An opposite-direction hall call only stops the car when it is the last call ahead.
    assign w_arr_stop   = w_cab_calls[w_arr_floor]
                        | (r_dir_up ? w_up_calls[w_arr_floor] : w_dn_calls[w_arr_floor])
                        | ((r_dir_up ? w_dn_calls[w_arr_floor] : w_up_calls[w_arr_floor]) & !w_arr_ahead);

    assign w_hall_ok    = hall_req && (hall_up ? (hall_floor != c_top_floor) : (hall_floor != floor_t'(0)));
    assign w_door_hit   = (cab_req && (cab_floor == r_cur_floor))
                        || (w_hall_ok && (hall_floor == r_cur_floor) && ((hall_up == r_dir_up) || !w_cur_ahead));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cur_floor <= '0;
            r_dir_up    <= 1'b1;
            r_timer     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_floor <= w_floor_nxt;
            r_dir_up    <= w_dir_nxt;
            r_timer     <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_floor_nxt = r_cur_floor;
        w_dir_nxt   = r_dir_up;
        w_timer_nxt = r_timer;
        w_clr_up    = '0;
        w_clr_dn    = '0;
        w_clr_cab   = '0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    if (w_all_calls[r_cur_floor]) begin
                        w_clr_up    = w_cur_oh;
                        w_clr_dn    = w_cur_oh;
                        w_clr_cab   = w_cur_oh;
                        w_timer_nxt = c_tmr_load;
                        w_state_nxt = DOOR;
                    end else if (w_above || w_below) begin
                        w_dir_nxt   = (w_above && w_below) ? r_dir_up : w_above;
                        w_state_nxt = MOVING;
                    end
                end
            end
            MOVING: begin
                if (enable && floor_arrive) begin
                    w_floor_nxt = w_arr_floor;
                    if (w_arr_stop) begin
                        w_clr_cab   = w_arr_oh;
                        w_clr_up    = (r_dir_up  || !w_arr_ahead) ? w_arr_oh : '0;
                        w_clr_dn    = (!r_dir_up || !w_arr_ahead) ? w_arr_oh : '0;
                        w_timer_nxt = c_tmr_load;
                        w_state_nxt = DOOR;
                    end
                end
            end
            DOOR: begin
                // Calls the open door already serves are swallowed and extend the dwell.
                w_clr_cab = w_cur_oh;
                w_clr_up  = (r_dir_up  || !w_cur_ahead) ? w_cur_oh : '0;
                w_clr_dn  = (!r_dir_up || !w_cur_ahead) ? w_cur_oh : '0;
                if (w_door_hit) begin
                    w_timer_nxt = c_tmr_load;
                end else if (enable) begin
                    if (r_timer != '0) begin
                        w_timer_nxt = r_timer - c_tmr_one;
                    end else if (w_cur_ahead) begin
                        w_state_nxt = MOVING;
                    end else if (w_cur_behind) begin
                        w_dir_nxt   = !r_dir_up;
                        w_state_nxt = MOVING;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign cur_floor  = r_cur_floor;
    assign dir_up     = r_dir_up;
    assign motor_up   = (r_state == MOVING) && r_dir_up;
    assign motor_down = (r_state == MOVING) && !r_dir_up;
    assign door_open  = (r_state == DOOR);
    assign pending    = w_all_calls;

endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_elevator_scheduler
// Description : Scoreboard bench: stimulus queues expected output snapshots,
//               a negedge monitor pops one per observed output change.
// Revision    : 1.0
// ============================================================================
module tb_elevator_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       hall_req = 1'b0;
    logic [1:0] hall_floor = 2'd0;
    logic       hall_up = 1'b0;
    logic       cab_req = 1'b0;
    logic [1:0] cab_floor = 2'd0;
    logic       floor_arrive = 1'b0;
    logic [1:0] cur_floor;
    logic       motor_up, motor_down, door_open, dir_up;
    logic [3:0] pending;

    elevator_scheduler #(.DOOR_CYCLES(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .hall_req     (hall_req),
        .hall_floor   (hall_floor),
        .hall_up      (hall_up),
        .cab_req      (cab_req),
        .cab_floor    (cab_floor),
        .floor_arrive (floor_arrive),
        .cur_floor    (cur_floor),
        .motor_up     (motor_up),
        .motor_down   (motor_down),
        .door_open    (door_open),
        .dir_up       (dir_up),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] vec;
        int         dt;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_chg = 0;
    logic [9:0] prev = 10'bx;

    always @(posedge clk) cyc = cyc + 1;

    // Snapshot layout: {cur_floor, motor_up, motor_down, door_open, dir_up, pending}
    always @(negedge clk) begin
        logic [9:0] now;
        exp_t       e;
        now = {cur_floor, motor_up, motor_down, door_open, dir_up, pending};
        checks++;
        if (motor_up && motor_down) begin
            errors++;
            $display("FAIL motor_exclusive got up=%b down=%b required not both at cycle %0d", motor_up, motor_down, cyc);
        end
        if (now !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got %b required no change at cycle %0d", now, cyc);
            end else begin
                e = exp_q.pop_front();
                if (now !== e.vec) begin
                    errors++;
                    $display("FAIL out_snapshot got fl=%0d up=%b dn=%b door=%b dir=%b pend=%b required fl=%0d up=%b dn=%b door=%b dir=%b pend=%b at cycle %0d",
                             now[9:8], now[7], now[6], now[5], now[4], now[3:0],
                             e.vec[9:8], e.vec[7], e.vec[6], e.vec[5], e.vec[4], e.vec[3:0], cyc);
                end
                if (e.dt != 0) begin
                    checks++;
                    if (cyc - last_chg != e.dt) begin
                        errors++;
                        $display("FAIL event_spacing got %0d cycles required %0d at cycle %0d", cyc - last_chg, e.dt, cyc);
                    end
                end
            end
            prev     = now;
            last_chg = cyc;
        end
    end

    task automatic push(input logic [1:0] fl, input logic mu, input logic md, input logic dr,
                        input logic dir, input logic [3:0] pend, input int dt);
        exp_t e;
        e.vec = {fl, mu, md, dr, dir, pend};
        e.dt  = dt;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cab(input logic [1:0] f);
        cab_req = 1'b1; cab_floor = f;
        tick(1);
        cab_req = 1'b0;
    endtask

    task automatic hall(input logic [1:0] f, input logic up);
        hall_req = 1'b1; hall_floor = f; hall_up = up;
        tick(1);
        hall_req = 1'b0;
    endtask

    task automatic arrive();
        floor_arrive = 1'b1;
        tick(1);
        floor_arrive = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    initial begin
        push(2'd0, 0, 0, 0, 1, 4'b0000, 0);
        tick(2);
        reset = 1'b0;

        // Cabin call to floor 3 from floor 0
        push(2'd0, 0, 0, 0, 1, 4'b1000, 0);
        push(2'd0, 1, 0, 0, 1, 4'b1000, 1);
        cab(2'd3);
        tick(2);
        push(2'd1, 1, 0, 0, 1, 4'b1000, 0);
        arrive(); tick(1);
        push(2'd2, 1, 0, 0, 1, 4'b1000, 0);
        arrive(); tick(1);
        push(2'd3, 0, 0, 1, 1, 4'b0000, 0);
        push(2'd3, 0, 0, 0, 1, 4'b0000, 8);
        arrive(); tick(12);
        push(2'd0, 0, 0, 0, 1, 4'b0000, 0);
        do_reset(); tick(1);

        // Simultaneous hall up @1 and cab @3: stop at 1, continue, stop at 3
        push(2'd0, 0, 0, 0, 1, 4'b1010, 0);
        push(2'd0, 1, 0, 0, 1, 4'b1010, 1);
        hall_req = 1'b1; hall_floor = 2'd1; hall_up = 1'b1;
        cab_req = 1'b1; cab_floor = 2'd3;
        tick(1);
        hall_req = 1'b0; cab_req = 1'b0;
        tick(2);
        push(2'd1, 0, 0, 1, 1, 4'b1000, 0);
        push(2'd1, 1, 0, 0, 1, 4'b1000, 8);
        arrive(); tick(10);
        push(2'd2, 1, 0, 0, 1, 4'b1000, 0);
        arrive(); tick(1);
        push(2'd3, 0, 0, 1, 1, 4'b0000, 0);
        push(2'd3, 0, 0, 0, 1, 4'b0000, 8);
        arrive(); tick(12);
        push(2'd0, 0, 0, 0, 1, 4'b0000, 0);
        do_reset(); tick(1);

        // Hall down @2 passed on the way up, served after reversal at 3
        push(2'd0, 0, 0, 0, 1, 4'b1000, 0);
        push(2'd0, 1, 0, 0, 1, 4'b1100, 1);
        cab(2'd3);
        hall(2'd2, 1'b0);
        tick(2);
        push(2'd1, 1, 0, 0, 1, 4'b1100, 0);
        arrive(); tick(1);
        push(2'd2, 1, 0, 0, 1, 4'b1100, 0);
        arrive(); tick(1);
        push(2'd3, 0, 0, 1, 1, 4'b0100, 0);
        push(2'd3, 0, 1, 0, 0, 4'b0100, 8);
        arrive(); tick(10);
        // Cabin call at the open floor on dwell cycle 5 restarts the dwell
        push(2'd2, 0, 0, 1, 0, 4'b0000, 0);
        push(2'd2, 0, 0, 0, 0, 4'b0000, 13);
        arrive();
        tick(4);
        cab(2'd2);
        tick(16);

        // Invalid hall calls are dropped; arrival pulses in IDLE are ignored
        hall(2'd3, 1'b1);
        hall(2'd0, 1'b0);
        tick(3);
        check("invalid_hall_pending", int'(pending), 0);
        check("invalid_hall_idle", int'({motor_up, motor_down, door_open}), 0);
        arrive(); tick(2);
        check("idle_arrive_floor", int'(cur_floor), 2);

        // Reset while moving down through floor 1
        push(2'd2, 0, 0, 0, 0, 4'b0001, 0);
        push(2'd2, 0, 1, 0, 0, 4'b0001, 1);
        cab(2'd0);
        tick(2);
        push(2'd1, 0, 1, 0, 0, 4'b0001, 0);
        arrive(); tick(2);
        check("pre_reset_floor", int'(cur_floor), 1);
        push(2'd0, 0, 0, 0, 1, 4'b0000, 0);
        reset = 1'b1;
        #1;
        check("rst_motor_up", int'(motor_up), 0);
        check("rst_motor_down", int'(motor_down), 0);
        check("rst_door_open", int'(door_open), 0);
        check("rst_cur_floor", int'(cur_floor), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_dir_up", int'(dir_up), 1);
        @(posedge clk); #1;
        reset = 1'b0;
        tick(1);

        // Call at the current floor opens the door; enable low stretches dwell by 5
        push(2'd0, 0, 0, 0, 1, 4'b0001, 0);
        push(2'd0, 0, 0, 1, 1, 4'b0000, 1);
        push(2'd0, 0, 0, 0, 1, 4'b0000, 13);
        cab(2'd0);
        tick(1);
        tick(2);
        enable = 1'b0;
        tick(5);
        check("frozen_door_open", int'(door_open), 1);
        enable = 1'b1;
        tick(16);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
